// File: rtl/seg7_scan_if.sv
// Connects a seven-segment scan driver to its pattern sources and to the display pins.
// The master side supplies per-digit patterns and controls; the slave side is the scan driver.
interface seg7_scan_if;
  logic [6:0] seg_in0;
  logic [6:0] seg_in1;
  logic [6:0] seg_in2;
  logic [6:0] seg_in3;
  logic [3:0] digit_en;
  logic [3:0] blink_mask;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  logic       frame_tick;

  modport master (
    output seg_in0, seg_in1, seg_in2, seg_in3, digit_en, blink_mask,
    input  seg_out, an_out, frame_tick
  );

  modport slave (
    input  seg_in0, seg_in1, seg_in2, seg_in3, digit_en, blink_mask,
    output seg_out, an_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver. It snapshots all inputs once per frame,
// scans one digit per slot with an anode-off guard interval, and supports per-digit enable and blink.
module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 500,
  parameter int BLINK_FRAMES   = 125,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);

  localparam int P_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [P_W-1:0]  P_LAST  = P_W'(REFRESH_DIV - 1);
  localparam logic [P_W-1:0]  GUARD_V = P_W'(GUARD);
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]      AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [P_W-1:0]  p_q, p_d;
  logic [1:0]      d_q, d_d;
  logic [BF_W-1:0] bf_q, bf_d;
  logic            ph_q, ph_d;

  logic [3:0][6:0] snap_seg_q, snap_seg_d;
  logic [3:0]      snap_en_q, snap_en_d;
  logic [3:0]      snap_blink_q, snap_blink_d;

  logic [6:0] seg_out_q, seg_out_d;
  logic [3:0] an_out_q, an_out_d;
  logic       frame_tick_q, frame_tick_d;

  logic       p_wrap;
  logic       load;
  logic       lit;
  logic [6:0] seg_on;
  logic [3:0] an_on;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    p_wrap       = (p_q == P_LAST);
    load         = (p_q == '0) && (d_q == 2'd0);
    p_d          = p_wrap ? '0 : p_q + P_W'(1);
    d_d          = p_wrap ? d_q + 2'd1 : d_q;
    snap_seg_d   = snap_seg_q;
    snap_en_d    = snap_en_q;
    snap_blink_d = snap_blink_q;
    bf_d         = bf_q;
    ph_d         = ph_q;
    frame_tick_d = load;

    // All six inputs are captured together so a frame never mixes old and new patterns.
    if (load) begin
      snap_seg_d[0] = bus.seg_in0;
      snap_seg_d[1] = bus.seg_in1;
      snap_seg_d[2] = bus.seg_in2;
      snap_seg_d[3] = bus.seg_in3;
      snap_en_d     = bus.digit_en;
      snap_blink_d  = bus.blink_mask;
      if (bf_q == BF_LAST) begin
        bf_d = '0;
        ph_d = ~ph_q;
      end else begin
        bf_d = bf_q + BF_W'(1);
      end
    end

    // Outputs are derived from the post-edge state so they carry no extra latency.
    lit    = (p_d >= GUARD_V) && snap_en_d[d_d] && (ph_d || !snap_blink_d[d_d]);
    seg_on = lit ? snap_seg_d[d_d] : 7'h00;
    an_on  = lit ? (4'b0001 << d_d) : 4'h0;

    seg_out_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    an_out_d  = SEG_ACTIVE_LOW ? ~an_on : an_on;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      p_q          <= '0;
      d_q          <= 2'd0;
      bf_q         <= '0;
      ph_q         <= 1'b1;
      // NOTE: the snapshot is a handful of flops, not a RAM, so resetting it costs nothing special.
      snap_seg_q   <= '0;
      snap_en_q    <= 4'h0;
      snap_blink_q <= 4'h0;
      seg_out_q    <= SEG_OFF;
      an_out_q     <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      d_q          <= d_d;
      bf_q         <= bf_d;
      ph_q         <= ph_d;
      snap_seg_q   <= snap_seg_d;
      snap_en_q    <= snap_en_d;
      snap_blink_q <= snap_blink_d;
      seg_out_q    <= seg_out_d;
      an_out_q     <= an_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.an_out     = an_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
